atmos_light_sched: RTL and testbench



---
 rtl/atmos_light_sched.sv | 165 ++++++++++++++++
 tb/tb_atmos_light_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/atmos_light_sched.sv
// Frame controller around the atmospheric-light estimator: checks frame geometry,
// collects A with a timeout, smooths/clamps it and offers it to the dehaze core.
module atmos_light_sched #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int SMOOTH_K    = 2,
  parameter int A_INIT      = 230,
  parameter int A_MIN       = 100,
  parameter int A_MAX       = 250,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_vsync,
  input  logic        frame_href,
  input  logic        frame_clken,
  input  logic [7:0]  a_result,
  input  logic        a_done,
  output logic [7:0]  cfg_a,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic        geom_err,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int PW = $clog2(IMG_W) + 1;
  localparam int LW = $clog2(IMG_H) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int SW = 8 + SMOOTH_K;

  typedef enum logic [2:0] {WAIT_FRAME, ACTIVE, WAIT_DONE, UPDATE, HANDSHAKE} state_t;

  state_t state, state_next;

  logic          vsync_d, href_d;
  logic          vs_rise, vs_fall, href_fall;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt, line_cnt_n;
  logic          line_bad, line_bad_n;
  logic          geom_ok;
  logic [TW-1:0] tmo;
  logic          done_pend;
  logic [7:0]    a_lat;
  logic          first_done;
  logic          got_done, tmo_hit, geom_set, tmo_set, drop_inc;
  logic [SW-1:0] a_sum;
  logic [7:0]    a_s, a_clamped;

  assign vs_rise   = frame_vsync & ~vsync_d;
  assign vs_fall   = vsync_d & ~frame_vsync;
  assign href_fall = href_d & ~frame_href;

  // A result that arrived together with the vsync fall counts as already received.
  assign got_done = a_done | done_pend;
  assign tmo_hit  = (tmo == TW'(TIMEOUT_CYC - 1));
  assign geom_set = (state == WAIT_DONE) & got_done & ~geom_ok;
  assign tmo_set  = (state == WAIT_DONE) & ~got_done & tmo_hit;
  assign drop_inc = vs_rise & ((state == WAIT_DONE) | (state == HANDSHAKE));

  assign a_sum     = SW'(cfg_a) * SW'((2 ** SMOOTH_K) - 1) + SW'(a_lat);
  assign a_s       = first_done ? a_sum[SMOOTH_K +: 8] : a_lat;
  assign a_clamped = (a_s < 8'(A_MIN)) ? 8'(A_MIN) :
                     (a_s > 8'(A_MAX)) ? 8'(A_MAX) : a_s;

  // Line bookkeeping including this cycle's href fall, so a line ending together
  // with vsync still counts toward the geometry verdict.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    line_cnt_n = line_cnt;
    line_bad_n = line_bad;
    if (href_fall) begin
      if (pix_cnt != PW'(IMG_W)) line_bad_n = 1'b1;
      if (line_cnt != '1)        line_cnt_n = line_cnt + LW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FRAME: if (vs_rise) state_next = ACTIVE;
      ACTIVE:     if (vs_fall) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (got_done)     state_next = geom_ok ? UPDATE : WAIT_FRAME;
        else if (tmo_hit) state_next = WAIT_FRAME;
      end
      UPDATE:     state_next = HANDSHAKE;
      HANDSHAKE:  if (cfg_valid && cfg_ready) state_next = WAIT_FRAME;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_bad    <= 1'b0;
      geom_ok     <= 1'b0;
      tmo         <= '0;
      done_pend   <= 1'b0;
      a_lat       <= '0;
      first_done  <= 1'b0;
      cfg_a       <= 8'(A_INIT);
      cfg_valid   <= 1'b0;
      geom_err    <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      vsync_d     <= frame_vsync;
      href_d      <= frame_href;
      geom_err    <= geom_set | (geom_err & ~err_clr);
      timeout_err <= tmo_set | (timeout_err & ~err_clr);
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        WAIT_FRAME: begin
          if (vs_rise) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_bad <= 1'b0;
          end
        end
        ACTIVE: begin
          line_cnt <= line_cnt_n;
          line_bad <= line_bad_n;
          if (href_fall)
            pix_cnt <= '0;
          else if (frame_href && frame_clken && pix_cnt != '1)
            pix_cnt <= pix_cnt + PW'(1);
          if (vs_fall) begin
            frame_cnt <= frame_cnt + 16'd1;
            geom_ok   <= ~line_bad_n & (line_cnt_n == LW'(IMG_H));
            tmo       <= '0;
            done_pend <= a_done;
            if (a_done) a_lat <= a_result;
          end
        end
        WAIT_DONE: begin
          if (a_done) a_lat <= a_result;
          if (got_done || tmo_hit) done_pend <= 1'b0;
          else                     tmo       <= tmo + TW'(1);
        end
        UPDATE: begin
          cfg_a      <= a_clamped;
          cfg_valid  <= 1'b1;
          first_done <= 1'b1;
        end
        HANDSHAKE: if (cfg_ready) cfg_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atmos_light_sched.sv
// Directed bench for atmos_light_sched: expected cfg_a values are queued when a_done
// is driven and compared when the core accepts the update.
module tb_atmos_light_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_vsync, frame_href, frame_clken;
  logic [7:0]  a_result;
  logic        a_done;
  logic [7:0]  cfg_a;
  logic        cfg_valid, cfg_ready;
  logic        geom_err, timeout_err, err_clr;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  logic [7:0] m_a = 8'd230;
  bit         m_first = 1'b1;

  atmos_light_sched #(
    .IMG_W(8), .IMG_H(4), .SMOOTH_K(2), .A_INIT(230),
    .A_MIN(100), .A_MAX(250), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_vsync(frame_vsync), .frame_href(frame_href), .frame_clken(frame_clken),
    .a_result(a_result), .a_done(a_done),
    .cfg_a(cfg_a), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .geom_err(geom_err), .timeout_err(timeout_err), .err_clr(err_clr),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Temporal IIR with K=2 followed by the [100,250] clamp.
  function automatic logic [7:0] model_next(input logic [7:0] prev, input logic [7:0] a,
                                            input bit first);
    int s;
    s = first ? int'(a) : (int'(prev) * 3 + int'(a)) / 4;
    if (s < 100) s = 100;
    if (s > 250) s = 250;
    return 8'(s);
  endfunction

  always @(negedge clk) begin
    if (!rst && cfg_valid && cfg_ready) begin
      logic [31:0] e;
      e = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
      check("sb_cfg_a", 32'(cfg_a), e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four lines of 8 pixels; bad_line gets 7. Returns just after the vs_fall edge.
  task automatic drive_frame(input int bad_line);
    frame_vsync = 1'b1;
    tick(); tick();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < ((l == bad_line) ? 7 : 8); p++) begin
        frame_href = 1'b1; frame_clken = 1'b1; tick();
      end
      frame_href = 1'b0; frame_clken = 1'b0;
      tick(); tick();
    end
    frame_vsync = 1'b0;
    tick();
  endtask

  task automatic pulse_done(input logic [7:0] a, input bit good);
    if (good) begin
      m_a = model_next(m_a, a, m_first);
      m_first = 1'b0;
      sb.push_back(m_a);
    end
    a_result = a;
    a_done   = 1'b1;
    tick();
    a_done   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_good(input logic [7:0] a, input string tag);
    drive_frame(-1);
    pulse_done(a, 1'b1);
    drain(tag);
  endtask

  initial begin
    rst = 1'b1;
    frame_vsync = 1'b0; frame_href = 1'b0; frame_clken = 1'b0;
    a_result = '0; a_done = 1'b0; cfg_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    check("rst_cfg_a", 32'(cfg_a), 32'd230);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_geom_err", 32'(geom_err), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // First clean frame: direct load, valid exactly one cycle.
    drive_frame(-1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    pulse_done(8'd200, 1'b1);
    check("t1_valid_early", 32'(cfg_valid), 32'd0);
    tick();
    check("t1_valid_high", 32'(cfg_valid), 32'd1);
    check("t1_cfg_a", 32'(cfg_a), 32'd200);
    tick();
    check("t1_valid_low", 32'(cfg_valid), 32'd0);

    // Smoothing, then drive toward the lower clamp.
    run_good(8'd120, "t2_drain_a");
    check("t2_cfg_a_180", 32'(cfg_a), 32'd180);
    for (int i = 0; i < 4; i++) run_good(8'd20, "t2_drain_b");
    check("t2_cfg_a_clamp", 32'(cfg_a), 32'd100);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd6);

    // Short line: geometry error, no update, then clear.
    drive_frame(2);
    pulse_done(8'd50, 1'b0);
    check("t3_geom_err", 32'(geom_err), 32'd1);
    tick(); tick();
    check("t3_no_valid", 32'(cfg_valid), 32'd0);
    check("t3_cfg_a_kept", 32'(cfg_a), 32'd100);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_geom_clr", 32'(geom_err), 32'd0);

    // Missing a_done: timeout on the 16th cycle; err_clr on that edge loses to set.
    drive_frame(-1);
    repeat (15) tick();
    check("t4_tmo_early", 32'(timeout_err), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_tmo_set", 32'(timeout_err), 32'd1);
    check("t4_cfg_a_kept", 32'(cfg_a), 32'd100);
    run_good(8'd240, "t4_drain");
    check("t4_cfg_a_135", 32'(cfg_a), 32'd135);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_tmo_clr", 32'(timeout_err), 32'd0);

    // Back-pressure across three frames: held offer, drops counted.
    cfg_ready = 1'b0;
    drive_frame(-1);
    pulse_done(8'd200, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      frame_vsync = 1'b1; tick(); tick();
      frame_vsync = 1'b0; tick(); tick();
      check("t5_valid_held", 32'(cfg_valid), 32'd1);
      check("t5_cfg_a_held", 32'(cfg_a), 32'd151);
    end
    check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd10);
    cfg_ready = 1'b1;
    drain("t5_drain");
    check("t5_valid_low", 32'(cfg_valid), 32'd0);
    run_good(8'd160, "t5_drain_next");
    check("t5_cfg_a_next", 32'(cfg_a), 32'd153);
    check("t5_frame_cnt_next", 32'(frame_cnt), 32'd11);

    // Reset during handshake, then unsmoothed first load.
    cfg_ready = 1'b0;
    drive_frame(-1);
    pulse_done(8'd90, 1'b0);
    tick();
    check("t6_valid_before", 32'(cfg_valid), 32'd1);
    check("t6_cfg_a_before", 32'(cfg_a), 32'd137);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(cfg_valid), 32'd0);
    check("t6_async_cfg_a", 32'(cfg_a), 32'd230);
    check("t6_async_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_async_drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b0;
    m_first = 1'b1;
    m_a = 8'd230;
    cfg_ready = 1'b1;
    tick();
    run_good(8'd180, "t6_drain");
    check("t6_first_load", 32'(cfg_a), 32'd180);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
